// File: rtl/i2s_clock_gen.sv
// Master-mode I2S clock generator: divides clk into bclk/lrclk with edge strobes.
// A divider change takes effect only at a frame wrap, so no short half-period is produced.
module i2s_clock_gen #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 3,
    parameter int BITS_PER_CH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] bclk_div,
    output logic             bclk,
    output logic             lrclk,
    output logic             bclk_rise,
    output logic             bclk_fall,
    output logic             frame_start
);

    localparam int FRAME_BITS = 2 * BITS_PER_CH;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(BITS_PER_CH);
    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] active_div;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_nxt;
    logic             toggle;
    logic             wrap;

    // Compare happens before increment, so div_cnt never exceeds active_div.
    assign toggle  = (div_cnt == active_div);
    assign bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    assign wrap    = toggle && bclk && (bit_nxt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt     <= '0;
            bit_cnt     <= '0;
            active_div  <= DIV_RST;
            bclk        <= 1'b0;
            lrclk       <= 1'b0;
            bclk_rise   <= 1'b0;
            bclk_fall   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            bclk_rise   <= 1'b0;
            bclk_fall   <= 1'b0;
            frame_start <= 1'b0;
            if (!enable) begin
                // Disable takes priority over any pending toggle or wrap.
                div_cnt    <= '0;
                bit_cnt    <= '0;
                bclk       <= 1'b0;
                lrclk      <= 1'b0;
                active_div <= bclk_div;
            end else if (!toggle) begin
                div_cnt <= div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
                bclk    <= ~bclk;
                if (!bclk) begin
                    bclk_rise <= 1'b1;
                end else begin
                    // lrclk only moves together with a bclk falling edge.
                    bclk_fall <= 1'b1;
                    bit_cnt   <= bit_nxt;
                    lrclk     <= (bit_nxt >= BIT_HALF);
                    if (wrap) begin
                        frame_start <= 1'b1;
                        active_div  <= bclk_div;
                    end
                end
            end
        end
    end

endmodule
